// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if
//   Request/response bus between the MEM stage and data_mem_ctrl.
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both high; the requester holds the request fields
//   stable while req_valid is high. Every accepted request gets exactly
//   one response on the following cycle: rsp_valid is a one-cycle pulse
//   that cannot be stalled, and rsp_error qualifies it.
//   master: requester side (drives req_*, address, wdata).
//   slave : memory side (drives req_ready, rsp_*, rdata, busy).
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_error;
  logic        busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, wdata,
    input  req_ready, rsp_valid, rdata, rsp_error, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, wdata,
    output req_ready, rsp_valid, rdata, rsp_error, busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Data memory for the MEM stage: byte/halfword/word loads and stores,
//   little-endian, byte-lane writes, registered reads with sign/zero
//   extension, a zeroing sweep after reset and an error response for
//   misaligned, out-of-range or illegal-size requests.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-high
//   bus       - data_mem_ctrl_if slave (request, response, busy)
//   dbg_state - current FSM state (0 = CLEAR, 1 = READY)
module data_mem_ctrl #(
  parameter int          DEPTH          = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus,
  output logic            dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     offset;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            in_range;
  logic            req_err;
  logic            accept;
  logic            do_store;
  logic            clear_we;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     load_val;

  logic            rsp_valid_q;
  logic            rsp_error_q;
  logic [31:0]     rdata_q;

  // BASE_ADDR is word-aligned, so the low offset bits equal the lane.
  assign offset   = bus.address - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign lane     = offset[1:0];
  // Unsigned offset: addresses below BASE_ADDR wrap high and fail here.
  assign in_range = (offset[31:AW+2] == '0);

  always_comb begin
    req_err = !in_range;
    case (bus.req_size)
      2'b00:   ;
      2'b01:   if (lane[0]) req_err = 1'b1;
      2'b10:   if (lane != 2'b00) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  // Requests presented while reset is high are dropped entirely.
  assign accept   = bus.req_valid && bus.req_ready && !reset;
  assign do_store = accept && bus.req_write && !req_err;
  assign clear_we = (state_q == ST_CLEAR) && !reset;

  // Replicate store data across lanes; the enables pick the target lanes.
  always_comb begin
    be = 4'b0000;
    wd = bus.wdata;
    case (bus.req_size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{bus.wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_cnt_q] <= 32'h0;
    end else if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // Load path reads the array at acceptance; a store committed on the
  // previous edge is therefore already visible.
  assign rword = mem[idx];

  always_comb begin
    case (lane)
      2'b00:   rbyte = rword[7:0];
      2'b01:   rbyte = rword[15:8];
      2'b10:   rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    case (bus.req_size)
      2'b00:   load_val = bus.req_unsigned ? {24'h0, rbyte}
                                           : {{24{rbyte[7]}}, rbyte};
      2'b01:   load_val = bus.req_unsigned ? {16'h0, rhalf}
                                           : {{16{rhalf[15]}}, rhalf};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      rsp_valid_q <= accept;
      rsp_error_q <= accept && req_err;
      rdata_q     <= (accept && !bus.req_write && !req_err) ? load_val : 32'h0;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign bus.req_ready = (state_q == ST_READY);
  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rdata     = rdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
//   Directed bench for data_mem_ctrl (DEPTH 32, BASE_ADDR 0, clear on).
//   A byte-array model of the memory predicts each response; a checker
//   compares every cycle's response outputs against the predictions, and
//   literal values from hand calculation pin the model.
module tb_data_mem_ctrl;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NB    = 4 * DEPTH;

  logic clk = 1'b0;
  logic reset;
  logic dbg_state;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mbytes [NB];
  logic [32:0] exp_q[$];   // {error, rdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) mbytes[i] = 8'h00;
  endtask

  // Memory as a flat little-endian byte array addressed by byte offset.
  function automatic logic [32:0] model_access(input logic w, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr,
                                               input logic [31:0] data);
    logic [31:0] off;
    logic [31:0] val;
    int          n;
    off = addr - BASE;
    if (size == 2'd3) return {1'b1, 32'h0};
    n = 1 << size;
    if ((off % n) != 0) return {1'b1, 32'h0};
    if (off >= NB) return {1'b1, 32'h0};
    val = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (w) mbytes[int'(off) + i] = data[8*i +: 8];
      else   val[8*i +: 8] = mbytes[int'(off) + i];
    end
    if (w) return 33'h0;
    if (!uns && size == 2'd0 && val[7])  val = val | 32'hFFFF_FF00;
    if (!uns && size == 2'd1 && val[15]) val = val | 32'hFFFF_0000;
    return {1'b0, val};
  endfunction

  // Response checker: every non-reset cycle.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
          end else begin
            e = exp_q.pop_front();
            check("rsp_error", {31'h0, bus.rsp_error}, {31'h0, e[32]});
            check("rsp_rdata", bus.rdata, e[31:0]);
          end
        end else begin
          check("idle_rdata", bus.rdata, 32'h0);
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            tests++; fails++;
            $display("FAIL missing_rsp: got rsp_valid=0 expected 1");
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where the response shows.
  task automatic do_req(input logic w, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rd, output logic err, output logic rv);
    logic acc;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.address      = addr;
    bus.wdata        = data;
    acc = bus.req_ready;
    @(posedge clk);
    #1;
    if (acc && !reset) exp_q.push_back(model_access(w, size, uns, addr, data));
    @(negedge clk);
    rd  = bus.rdata;
    err = bus.rsp_error;
    rv  = bus.rsp_valid;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check(name, n, DEPTH);
  endtask

  task automatic do_reset(input int cycles);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h1);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rsp_error", {31'h0, bus.rsp_error}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    reset = 1'b0;
    exp_q.delete();
    model_clear();
  endtask

  logic [31:0] rd, rd2;
  logic        er, rv, rv2;

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.address = 32'h0;
    bus.wdata = 32'h0;
    model_clear();
    @(negedge clk);
    do_reset(2);
    wait_ready("clear_len_initial");

    // Pre-load, then reset: memory must come back zeroed.
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, 2'b10, 1'b0, 32'(4 * i), 32'hA5A5_0000 | 32'(i), rd, er, rv);
    do_req(1'b0, 2'b10, 1'b0, 32'd60, 32'h0, rd, er, rv);
    check("preload_lw15", rd, 32'hA5A5_000F);
    idle();
    do_reset(1);
    wait_ready("clear_len_after_preload");
    do_req(1'b0, 2'b10, 1'b0, 32'd0,   32'h0, rd, er, rv); check("clr_idx0", rd, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'd60,  32'h0, rd, er, rv); check("clr_idx15", rd, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'd124, 32'h0, rd, er, rv); check("clr_idx31", rd, 32'h0);

    // Byte / halfword stores.
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, rd, er, rv);
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_00AA, rd, er, rv);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, rv);
    check("sb_merge", rd, 32'h1122_AA44);
    do_req(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_BEEF, rd, er, rv);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, rv);
    check("sh_merge", rd, 32'hBEEF_AA44);

    // Extension.
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h80FF_7F01, rd, er, rv);
    do_req(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, rd, er, rv); check("lb_6", rd, 32'hFFFF_FFFF);
    do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, rd, er, rv); check("lbu_7", rd, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, rd, er, rv); check("lh_4", rd, 32'h0000_7F01);
    do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, rd, er, rv); check("lh_6", rd, 32'hFFFF_80FF);
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, rd, er, rv); check("lhu_6", rd, 32'h0000_80FF);
    do_req(1'b0, 2'b10, 1'b1, 32'h4, 32'h0, rd, er, rv); check("lw_uns_4", rd, 32'h80FF_7F01);

    // Errors: each must flag and leave memory alone.
    do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, rd, er, rv);
    check("err_lw2", {31'h0, er}, 32'h1); check("err_lw2_rdata", rd, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h3, 32'h1234_5678, rd, er, rv);
    check("err_sh3", {31'h0, er}, 32'h1); check("err_sh3_rdata", rd, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'h1234_5678, rd, er, rv);
    check("err_size3", {31'h0, er}, 32'h1); check("err_size3_rdata", rd, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, BASE + 32'(NB), 32'h1234_5678, rd, er, rv);
    check("err_range", {31'h0, er}, 32'h1); check("err_range_rdata", rd, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, rd, er, rv);
    check("err_wrap", {31'h0, er}, 32'h1);
    do_req(1'b1, 2'b00, 1'b0, 32'h7F, 32'h0000_0055, rd, er, rv);
    check("ok_last_byte", {31'h0, er}, 32'h0);
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, rd, er, rv);
    check("readback_w2", rd, 32'h5500_0000);

    // Back-to-back store then load to the same word.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, rv);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd2, er, rv2);
    check("tput_rv1", {31'h0, rv}, 32'h1);
    check("tput_rv2", {31'h0, rv2}, 32'h1);
    check("tput_rdata", rd2, 32'hDEAD_BEEF);
    idle();

    // Reset at clear cycle 10, then the full clear must run again.
    do_reset(1);
    repeat (10) @(negedge clk);
    check("midclr_busy", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready("clear_len_midclear");
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, rv); check("midclr_idx4", rd, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0,  32'h0, rd, er, rv); check("midclr_idx0", rd, 32'h0);
    idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
